// File: rtl/npc_lsu.sv
// npc_lsu: single-outstanding load/store unit with alignment checking and lane steering
module npc_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, DATA, RESP} state_t;
  state_t state, state_nx;
  logic [31:0] addr_q, st_data, sh, ld;
  logic [7:0]  st_mask;
  logic [1:0]  off, size;
  logic        uns, bad, accept, st;
  assign req_ready  = state == IDLE;
  assign mem_valid  = state == ISSUE;
  assign resp_valid = state == RESP;
  assign mem_raddr  = addr_q;
  assign mem_waddr  = addr_q;
  assign accept     = req_valid & req_ready;
  assign bad = (req_size == 2'd3) | ((req_size == 2'd1) & req_addr[0]) |
               ((req_size == 2'd2) & |req_addr[1:0]);
  assign st  = req_wen & ~bad;
  always_comb begin
    st_data = req_size == 2'd0 ? {24'b0, req_wdata[7:0]} << {req_addr[1:0], 3'b0} :
              req_size == 2'd1 ? {16'b0, req_wdata[15:0]} << {req_addr[1], 4'b0} : req_wdata;
    st_mask = req_size == 2'd0 ? 8'h01 << req_addr[1:0] :
              req_size == 2'd1 ? 8'h03 << req_addr[1:0] : 8'h0F;
    sh      = mem_rdata >> {off, 3'b0};
    ld      = size == 2'd0 ? {{24{~uns & sh[7]}}, sh[7:0]} :
              size == 2'd1 ? {{16{~uns & sh[15]}}, sh[15:0]} : sh;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = bad ? RESP : ISSUE;
      ISSUE:   state_nx = mem_wen ? RESP : DATA;
      DATA:    state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      off        <= '0;
      size       <= '0;
      uns        <= 1'b0;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q     <= {req_addr[31:2], 2'b00};
        off        <= req_addr[1:0];
        size       <= req_size;
        uns        <= req_unsigned;
        mem_wen    <= st;
        mem_wdata  <= st ? st_data : '0;
        mem_wmask  <= st ? st_mask : '0;
        resp_rdata <= '0;
        resp_err   <= bad;
      end
      if (state == DATA) resp_rdata <= ld;
    end
  end
endmodule

// File: doc/npc_lsu.md
NPC_LSU -- requirements
Module: npc_lsu

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  upstream load/store request present.
REQ-005 req_ready  out  1  LSU can accept a request.
REQ-006 req_wen  in  1  1 = store, 0 = load.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_wdata  in  32  store data, right-justified.
REQ-009 req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-010 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-011 resp_valid  out  1  response present.
REQ-012 resp_ready  in  1  upstream accepts the response.
REQ-013 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-014 resp_err  out  1  misaligned or illegal-size request.
REQ-015 mem_valid  out  1  memory request strobe.
REQ-016 mem_wen  out  1  memory write enable.
REQ-017 mem_raddr / mem_waddr  out  32 each  word-aligned address, {req_addr[31:2],2'b00}, both driven identically.
REQ-018 mem_wdata  out  32  lane-shifted store data.
REQ-019 mem_wmask  out  8  byte-enable mask; bits [7:4] always 0.
REQ-020 mem_rdata  in  32  memory read data, valid in the cycle after a read strobe edge.

Function
REQ-021 FSM states are IDLE, ISSUE, DATA and RESP; every mem_* and resp_* output is driven from registers or from the state only.
REQ-022 req_ready is 1 only in IDLE; a request is accepted on a posedge with req_valid & req_ready, and all request fields are latched at that edge.
REQ-023 Alignment check at acceptance: half with addr[0]=1, word with addr[1:0]!=0, or size=3 -> error; the FSM goes IDLE->RESP with resp_err=1 and resp_rdata=0, and mem_valid is never asserted.
REQ-024 On a legal request the FSM goes IDLE->ISSUE; in ISSUE mem_valid=1 for exactly one cycle and mem_wen=latched wen.
REQ-025 Store lanes: byte -> wdata[7:0]<<(8*addr[1:0]) with wmask=8'h01<<addr[1:0]; half -> wdata[15:0]<<(8*addr[1]*2) with wmask=8'h03<<addr[1:0]; word -> wdata with wmask=8'h0F.
REQ-026 Loads drive mem_wmask=0 and mem_wdata=0.
REQ-027 Store path is ISSUE->RESP, with resp_rdata=0 and resp_err=0.
REQ-028 Load path is ISSUE->DATA; in DATA, mem_rdata is shifted right by 8*addr[1:0], truncated to size, extended per req_unsigned, and registered into resp_rdata; the FSM then goes DATA->RESP.
REQ-029 In RESP, resp_valid=1 and resp_rdata/resp_err hold stable until resp_ready=1; the handshake edge returns the FSM to IDLE.
REQ-030 A new request is not accepted in the same cycle as a response handshake.
REQ-031 Minimum latency from acceptance edge to resp_valid: load 3 cycles, store 2 cycles, error 1 cycle.
REQ-032 mem_valid is 0 in every state other than ISSUE.

Reset
REQ-033 rst_n=0 immediately forces state=IDLE, mem_valid=0, mem_wen=0, mem_wmask=0, mem_wdata=0, mem_raddr=mem_waddr=0, resp_valid=0, resp_rdata=0 and resp_err=0, independent of clk.
REQ-034 Reset asserted in ISSUE, DATA or RESP abandons the transaction; no response is produced after reset releases.
REQ-035 After rst_n rises, req_ready=1 on the first cycle.

Verification
REQ-036 Word load at 0x80000004, memory returns 0xDEADBEEF -> mem_raddr=0x80000004, wmask=0; resp_rdata=0xDEADBEEF 3 cycles after acceptance; resp_err=0.
REQ-037 Signed byte load at 0x80000003, memory word 0x80FF1234 -> resp_rdata=0xFFFFFF80; the same access with req_unsigned=1 -> resp_rdata=0x00000080.
REQ-038 Half store of 0x0000ABCD at 0x80000002 -> one mem_valid cycle with mem_wen=1, mem_waddr=0x80000000, mem_wdata=0xABCD0000, mem_wmask=0x0C; resp_valid 2 cycles after acceptance.
REQ-039 Word load at 0x80000001 -> mem_valid stays 0; resp_valid next cycle with resp_err=1 and resp_rdata=0.
REQ-040 resp_ready held 0 for 5 cycles in RESP -> resp_valid and data stable, req_ready=0 throughout; the handshake edge then yields req_ready=1.
REQ-041 rst_n pulsed low during ISSUE of a store -> mem_valid drops to 0 asynchronously; no resp_valid after release; the next request completes normally.
